// File: rtl/pong_pkg.sv
// Shared types and constants for the PONG game datapath.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned CENTRE_X = 320;
  localparam int unsigned CENTRE_Y = 240;

  localparam int unsigned SCORE_W_DEF = 6;

endpackage

// File: rtl/pong_btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for a raw push button.
module pong_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  // One-cycle pulse on the first synchronised cycle the button reads high.
  assign rise_c = sync & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// PONG game-flow sequencer: serve/play/pause/point/over, scoring and flash.
// Optional PONG_WIN_BY_TWO_EN: a win additionally needs a lead of two points.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned SCORE_W      = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               run_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] lscore,
  output logic [SCORE_W-1:0] rscore,
  output logic [1:0]         winner,
  output logic               flash,
  output logic [2:0]         state
);

  localparam int unsigned SERVE_LOAD = (SERVE_FRAMES == 0) ? 1 : SERVE_FRAMES;
  localparam int unsigned POINT_LOAD = (POINT_FRAMES == 0) ? 1 : POINT_FRAMES;
  localparam int unsigned MAX_LOAD   = (SERVE_LOAD > POINT_LOAD) ? SERVE_LOAD : POINT_LOAD;
  localparam int unsigned TIMER_W    = ($clog2(MAX_LOAD + 1) < 4) ? 4 : $clog2(MAX_LOAD + 1);

  localparam logic [TIMER_W-1:0] SERVE_INIT = TIMER_W'(SERVE_LOAD);
  localparam logic [TIMER_W-1:0] POINT_INIT = TIMER_W'(POINT_LOAD);
  localparam logic [SCORE_W-1:0] SCORE_TOP  = '1;
  localparam logic [SCORE_W-1:0] WIN_AT     = SCORE_W'(WIN_SCORE);

  state_t             st;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_dec;
  logic               timer_last;
  logic               start_ev;
  logic [SCORE_W-1:0] l_next;
  logic [SCORE_W-1:0] r_next;

  pong_btn_edge u_start (
    .clk    (clk),
    .rst    (rst),
    .btn    (start_btn),
    .rise_c (start_ev)
  );

  assign timer_dec  = timer - TIMER_W'(1);
  assign timer_last = (timer <= TIMER_W'(1));

  // Saturating post-point scores; only meaningful when exactly one miss is seen.
  assign l_next = (miss_r && lscore != SCORE_TOP) ? lscore + SCORE_W'(1) : lscore;
  assign r_next = (miss_l && rscore != SCORE_TOP) ? rscore + SCORE_W'(1) : rscore;

  function automatic logic [1:0] judge(input logic [SCORE_W-1:0] l, input logic [SCORE_W-1:0] r);
`ifdef PONG_WIN_BY_TWO_EN
    logic [SCORE_W:0] lw;
    logic [SCORE_W:0] rw;
    lw = {1'b0, l};
    rw = {1'b0, r};
    // A saturated score can no longer grow, so the leader takes it there.
    if (l == SCORE_TOP || r == SCORE_TOP) return (l > r) ? WIN_L : WIN_R;
    if (l >= WIN_AT && lw >= rw + (SCORE_W + 1)'(2)) return WIN_L;
    if (r >= WIN_AT && rw >= lw + (SCORE_W + 1)'(2)) return WIN_R;
`else
    if (l >= WIN_AT) return WIN_L;
    if (r >= WIN_AT) return WIN_R;
`endif
    return WIN_NONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      timer      <= '0;
      lscore     <= '0;
      rscore     <= '0;
      run_en     <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b1;
      winner     <= WIN_NONE;
      flash      <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (start_ev) begin
            st         <= ST_SERVE;
            timer      <= SERVE_INIT;
            ball_reset <= 1'b1;
            run_en     <= 1'b0;
            flash      <= 1'b0;
            lscore     <= '0;
            rscore     <= '0;
            winner     <= WIN_NONE;
            serve_dir  <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (timer_last) begin
              st     <= ST_PLAY;
              run_en <= 1'b1;
            end else begin
              timer <= timer_dec;
            end
          end
        end
        ST_PLAY: begin
          if (miss_l && miss_r) begin
            st         <= ST_SERVE;
            timer      <= SERVE_INIT;
            ball_reset <= 1'b1;
            run_en     <= 1'b0;
          end else if (miss_l || miss_r) begin
            st        <= ST_POINT;
            timer     <= POINT_INIT;
            run_en    <= 1'b0;
            flash     <= POINT_INIT[3];
            lscore    <= l_next;
            rscore    <= r_next;
            serve_dir <= (r_next > l_next);
            winner    <= judge(l_next, r_next);
          end else if (start_ev) begin
            st     <= ST_PAUSE;
            run_en <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start_ev) begin
            st     <= ST_PLAY;
            run_en <= 1'b1;
          end
        end
        ST_POINT: begin
          if (frame_tick) begin
            if (timer_last) begin
              if (winner != WIN_NONE) begin
                st    <= ST_OVER;
                flash <= 1'b1;
              end else begin
                st         <= ST_SERVE;
                timer      <= SERVE_INIT;
                ball_reset <= 1'b1;
                flash      <= 1'b0;
              end
            end else begin
              timer <= timer_dec;
              flash <= timer_dec[3];
            end
          end
        end
        default: begin
          st     <= ST_IDLE;
          timer  <= '0;
          run_en <= 1'b0;
          flash  <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl with WIN_SCORE=3, SERVE_FRAMES=4, POINT_FRAMES=4.
module tb_pong_game_ctrl;

  localparam int unsigned SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_tick;
  logic          start_btn;
  logic          miss_l;
  logic          miss_r;
  logic          run_en;
  logic          ball_reset;
  logic          serve_dir;
  logic [SW-1:0] lscore;
  logic [SW-1:0] rscore;
  logic [1:0]    winner;
  logic          flash;
  logic [2:0]    state;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (4),
    .POINT_FRAMES (4),
    .SCORE_W      (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .miss_l     (miss_l),
    .miss_r     (miss_r),
    .run_en     (run_en),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .lscore     (lscore),
    .rscore     (rscore),
    .winner     (winner),
    .flash      (flash),
    .state      (state)
  );

  typedef struct {
    int            cyc;
    logic [2:0]    st;
    logic          run;
    logic          brst;
    logic          sdir;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [1:0]    win;
    logic          fl;
    int            pulses;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    cyc    = 0;
  int    tests  = 0;
  int    fails  = 0;
  int    pulses = 0;

  logic [2:0]    e_st;
  logic          e_run, e_brst, e_sdir, e_fl;
  logic [SW-1:0] e_l, e_r;
  logic [1:0]    e_win;
  int            e_pulses;

  exp_t  m_e;
  string m_n;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count ball_reset cycles and check any expectation due this cycle.
  always @(negedge clk) begin
    if (ball_reset === 1'b1) pulses = pulses + 1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      m_n = nq.pop_front();
      tests = tests + 1;
      if (state !== m_e.st || run_en !== m_e.run || ball_reset !== m_e.brst ||
          serve_dir !== m_e.sdir || lscore !== m_e.l || rscore !== m_e.r ||
          winner !== m_e.win || flash !== m_e.fl || pulses != m_e.pulses || m_e.cyc != cyc) begin
        fails = fails + 1;
        $display("FAIL %s: got st=%0d run=%0b brst=%0b sdir=%0b l=%0d r=%0d win=%0d fl=%0b pulses=%0d cyc=%0d, want st=%0d run=%0b brst=%0b sdir=%0b l=%0d r=%0d win=%0d fl=%0b pulses=%0d cyc=%0d",
                 m_n, state, run_en, ball_reset, serve_dir, lscore, rscore, winner, flash, pulses, cyc,
                 m_e.st, m_e.run, m_e.brst, m_e.sdir, m_e.l, m_e.r, m_e.win, m_e.fl, m_e.pulses, m_e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
    end
  endtask

  task automatic press();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(2);
  endtask

  task automatic snap(input string name);
    exp_t e;
    e.cyc    = cyc;
    e.st     = e_st;
    e.run    = e_run;
    e.brst   = e_brst;
    e.sdir   = e_sdir;
    e.l      = e_l;
    e.r      = e_r;
    e.win    = e_win;
    e.fl     = e_fl;
    e.pulses = e_pulses;
    q.push_back(e);
    nq.push_back(name);
  endtask

  task automatic serve_entry();
    e_st     = 3'd1;
    e_run    = 1'b0;
    e_fl     = 1'b0;
    e_brst   = 1'b1;
    e_pulses = e_pulses + 1;
  endtask

  // One point from PLAY: expected scores/winner given by hand; ends in PLAY or OVER.
  task automatic play_point(input logic ml, input logic mr, input int el, input int er,
                            input logic [1:0] ew, input string name);
    miss_l = ml;
    miss_r = mr;
    step(1);
    miss_l = 1'b0;
    miss_r = 1'b0;
    e_l = SW'(el); e_r = SW'(er); e_win = ew;
    e_st = 3'd4; e_run = 1'b0; e_fl = 1'b0; e_sdir = (er > el);
    snap({name, "_point"});
    ticks(4);
    if (ew != 2'b00) begin
      e_st = 3'd5; e_fl = 1'b1;
      snap({name, "_over"});
    end else begin
      serve_entry();
      snap({name, "_serve"});
      e_brst = 1'b0;
      ticks(4);
      e_st = 3'd2; e_run = 1'b1;
      snap({name, "_play"});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    e_st = 3'd0; e_run = 1'b0; e_brst = 1'b0; e_sdir = 1'b1; e_l = '0; e_r = '0;
    e_win = 2'b00; e_fl = 1'b0; e_pulses = 0;

    step(3);
    snap("reset");
    rst = 1'b0;
    start_btn = 1'b1;
    step(2);
    snap("start_lat2");
    step(1);
    serve_entry();
    snap("start_serve");
    e_brst = 1'b0;
    step(1);
    snap("brst_once");
    ticks(3);
    snap("serve_3ticks");
    ticks(1);
    e_st = 3'd2; e_run = 1'b1;
    snap("serve_to_play");
    step(2);
    start_btn = 1'b0;
    step(3);
    snap("held_once");

    play_point(1'b1, 1'b0, 0, 1, 2'b00, "miss_l");

    miss_l = 1'b1; miss_r = 1'b1;
    step(1);
    miss_l = 1'b0; miss_r = 1'b0;
    serve_entry();
    snap("replay");
    e_brst = 1'b0;
    ticks(4);
    e_st = 3'd2; e_run = 1'b1;
    snap("replay_play");

    press();
    e_st = 3'd3; e_run = 1'b0;
    snap("pause");
    miss_r = 1'b1;
    step(1);
    miss_r = 1'b0;
    snap("pause_miss_ign");
    press();
    e_st = 3'd2; e_run = 1'b1;
    snap("resume");

    play_point(1'b0, 1'b1, 1, 1, 2'b00, "pt_l1");
    play_point(1'b0, 1'b1, 2, 1, 2'b00, "pt_l2");
    play_point(1'b0, 1'b1, 3, 1, 2'b01, "pt_l3");
    miss_l = 1'b1;
    step(1);
    miss_l = 1'b0;
    snap("over_miss_ign");

    press();
    serve_entry();
    e_l = '0; e_r = '0; e_win = 2'b00; e_sdir = 1'b1;
    snap("new_game");
    e_brst = 1'b0;
    ticks(4);
    e_st = 3'd2; e_run = 1'b1;
    snap("new_play");

    // Start edge lands on the same clock as a miss.
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(1);
    miss_l = 1'b1;
    step(1);
    miss_l = 1'b0;
    e_st = 3'd4; e_run = 1'b0; e_r = SW'(1); e_sdir = 1'b1;
    snap("miss_beats_start");
    ticks(4);
    serve_entry();
    snap("mbs_serve");
    e_brst = 1'b0;
    miss_r = 1'b1;
    step(1);
    miss_r = 1'b0;
    snap("serve_miss_ign");
    ticks(4);
    e_st = 3'd2; e_run = 1'b1;
    snap("mbs_play");

`ifdef PONG_WIN_BY_TWO_EN
    play_point(1'b0, 1'b1, 1, 1, 2'b00, "b2_11");
    play_point(1'b1, 1'b0, 1, 2, 2'b00, "b2_12");
    play_point(1'b0, 1'b1, 2, 2, 2'b00, "b2_22");
    play_point(1'b1, 1'b0, 2, 3, 2'b00, "b2_23");
    play_point(1'b0, 1'b1, 3, 3, 2'b00, "b2_33");
    play_point(1'b0, 1'b1, 4, 3, 2'b00, "b2_43");
    play_point(1'b0, 1'b1, 5, 3, 2'b01, "b2_53");
`else
    play_point(1'b0, 1'b1, 1, 1, 2'b00, "r_11");
    play_point(1'b1, 1'b0, 1, 2, 2'b00, "r_12");
    play_point(1'b0, 1'b1, 2, 2, 2'b00, "r_22");
    play_point(1'b1, 1'b0, 2, 3, 2'b10, "r_23");
`endif

    step(2);
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-flow sequencer for the PONG datapath: decides when the ball may move, when it is re-centred, which way it serves, and keeps the score.
- Runs on the pixel clock and advances its timers on the per-frame tick (x==0 && y==0) that also drives ball and paddle motion.
- The renderer consumes `run_en`, `ball_reset` and `serve_dir`, and reports misses back on `miss_l` / `miss_r`.
- Scores and `flash` feed the score-bar and border drawing.

Parameters:
- WIN_SCORE, 11, points needed to win; must be < 2**SCORE_W-1.
- SERVE_FRAMES, 60, frames the ball is held centred before each serve; 0 is treated as 1.
- POINT_FRAMES, 90, frames of the post-point pause; 0 is treated as 1.
- SCORE_W, 6, score counter width.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame.
- start_btn  in  1  raw, asynchronous start/pause button.
- miss_l  in  1  ball passed the left edge; right player scores.
- miss_r  in  1  ball passed the right edge; left player scores.
- run_en  out  1  ball motion enable.
- ball_reset  out  1  one-cycle pulse: re-centre ball to (320,240).
- serve_dir  out  1  1 = serve rightward, 0 = leftward.
- lscore  out  SCORE_W  left score.
- rscore  out  SCORE_W  right score.
- winner  out  2  00 none, 01 left, 10 right.
- flash  out  1  score/border blink.
- state  out  3  current state code.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; timer=0; scores=0.
  - run_en=0, ball_reset=0, serve_dir=1, winner=00, flash=0.
  - Synchroniser and edge registers cleared.
- Reset mid-game abandons the game immediately; no ball_reset pulse is emitted on reset.
- Start edge (`start_ev`):
  - start_btn passes through a 2-FF synchroniser, then a rising-edge detector.
  - The resulting state change is visible 3 clocks after start_btn rises.
  - Held buttons produce one event only.
- State codes: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5. Unused codes recover to IDLE.
- `run_en` is 1 only in PLAY. `flash` is 0 outside POINT and OVER.
- Timer rule: a load of N (N≥1) means the exit occurs on the Nth subsequent frame_tick. The timer decrements only on frame_tick.
- IDLE:
  - start_ev → SERVE.
  - Clears scores and winner, sets serve_dir=1, loads SERVE_FRAMES.
- SERVE: timer expiry → PLAY.
- Entry to SERVE from any state pulses ball_reset for exactly the first cycle in SERVE.
- PLAY:
  - start_ev → PAUSE; timer holds.
  - miss_l alone → rscore+1 → POINT.
  - miss_r alone → lscore+1 → POINT.
  - miss_l and miss_r in the same cycle → no score, direct to SERVE (replay).
  - start_ev coincident with a miss: the miss wins.
  - On POINT entry:
    - serve_dir = (new rscore > new lscore).
    - Load POINT_FRAMES.
    - If a score reached WIN_SCORE, latch winner.
- PAUSE:
  - start_ev → PLAY.
  - miss inputs ignored.
- POINT:
  - flash = timer[3].
  - On timer expiry: winner≠00 → OVER; else → SERVE with SERVE_FRAMES loaded.
- OVER:
  - flash = 1; scores and winner held.
  - start_ev behaves as in IDLE: new game, → SERVE.
- Misses in any state other than PLAY are ignored.
- Scores never wrap; increments are blocked at 2**SCORE_W-1.
- All outputs are registered.

Optional Feature:
- Macro: PONG_WIN_BY_TWO_EN.
- Defined: the win requires leader ≥ WIN_SCORE and lead ≥ 2.
  - If either score reaches 2**SCORE_W-1, the current leader wins immediately.
  - A tie at that point is impossible, because increments are blocked.
- Undefined: the first player to reach WIN_SCORE wins.

Decomposition:
- Package `pong_pkg`:
  - State enum and codes; winner codes WIN_NONE/WIN_L/WIN_R.
  - Screen constants (640x480, centre 320/240).
  - Default SCORE_W.
- Sub-module `pong_btn_edge`: 2-FF synchroniser plus rising-edge detector, with its own rst. It is reused for paddle buttons later.

Test Plan (WIN_SCORE=3, SERVE_FRAMES=4, POINT_FRAMES=4):
- Reset, then start_btn high for 10 clocks:
  - state=1 on clock 3; ball_reset high for exactly 1 cycle.
  - After the 4th frame_tick, state=2 and run_en=1.
- In PLAY, miss_l pulse:
  - rscore=1, serve_dir=1, state=4, flash follows timer[3].
  - After 4 ticks, state=1 with a ball_reset pulse.
- miss_l and miss_r together in PLAY: scores unchanged, state=1, ball_reset pulses.
- Start edge in PLAY:
  - state=3, run_en=0; miss_r ignored.
  - Second edge → state=2; timer and scores unchanged.
- Three miss_r points:
  - lscore=3, winner=01, state=5 after the POINT timer, flash=1.
  - Start edge → scores 0, winner 00, state=1.
- With PONG_WIN_BY_TWO_EN, points alternate to 3-3, then the left player scores (4-3): winner stays 00. A further left point (5-3): winner=01.
